serial_adder_ctrl: RTL

- Bit-serial addition controller. It time-multiplexes one single-bit full-adder cell across the bit positions of two WIDTH-bit operands, one bit per clock, LSB first.
- It owns operand capture, the carry flip-flop, the bit counter and the start/done handshake.
- It is the low-area alternative to the ripple-carry datapath and returns the same {c_out, sum} result.

---
 rtl/serial_adder_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH clocks,
// returning {c_out, sum} = in1 + in2 + c_in with a start/busy/done handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; last result held on sum/c_out
// ADD   | one bit per clock through the full-adder cell, busy=1
// DONE  | single-cycle done pulse; start here reloads straight into ADD
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             co_bit;
    logic             last_bit;

    always_comb begin
        s_bit  = op_a[0] ^ op_b[0] ^ carry;
        co_bit = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            partial <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state)
                ADD: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    partial <= {s_bit, partial[WIDTH-1:1]};
                    carry   <= co_bit;
                    cnt     <= cnt + CNT_W'(1);
                    // Result registers move only here, so they never show a partial value.
                    if (last_bit) begin
                        sum   <= {s_bit, partial[WIDTH-1:1]};
                        c_out <= co_bit;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start; DONE otherwise falls back to IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        op_a    <= in1;
                        op_b    <= in2;
                        carry   <= c_in;
                        cnt     <= '0;
                        partial <= '0;
                        state   <= ADD;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
